// File: rtl/mips_pkg.sv
// Shared definitions for the single-issue MIPS datapath: opcodes, fetch FSM
// encoding, the NOP word and the branch offset helper.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_REQ   = 2'd1;
    localparam logic [1:0] ST_ISSUE = 2'd2;

    localparam logic [31:0] NOP = 32'h0000_0000;

    typedef enum logic [1:0] {
        SEL_SEQ    = 2'd0,
        SEL_BRANCH = 2'd1,
        SEL_JUMP   = 2'd2
    } pc_sel_e;

    // Word offset of a BEQ immediate, as a byte offset in the 32-bit PC space
    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/next_pc_calc.sv
// Next-PC select for the fetch stage: jump over taken branch over sequential.
// Pure combinational; the caller decides when the result is consumed.
module next_pc_calc
    import mips_pkg::*;
(
    input  logic [31:0] pc_plus4,
    input  logic [25:0] instr_index,
    input  logic        jump,
    input  logic        branch,
    input  logic        zero,
    input  logic [15:0] branch_imm,
    output logic [31:0] next_pc
);

    pc_sel_e     pc_sel;
    logic [31:0] jump_target;
    logic [31:0] branch_target;

    assign jump_target   = {pc_plus4[31:28], instr_index, 2'b00};
    assign branch_target = pc_plus4 + branch_offset(branch_imm);

    always_comb begin
        pc_sel = SEL_SEQ;
        if (jump) begin
            pc_sel = SEL_JUMP;
        end else if (branch && zero) begin
            pc_sel = SEL_BRANCH;
        end
    end

    always_comb begin
        next_pc = pc_plus4;
        case (pc_sel)
            SEL_JUMP:   next_pc = jump_target;
            SEL_BRANCH: next_pc = branch_target;
            default:    next_pc = pc_plus4;
        endcase
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Sequential instruction fetch: owns the PC, handshakes with instruction
// memory and issues one instruction at a time to the control unit.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | one settling cycle after reset, no request outstanding
// ST_REQ   | imem_req high, imem_addr = pc held until imem_ready
// ST_ISSUE | instr_out valid; leave on !stall with the redirected PC
module instr_fetch_unit
    import mips_pkg::*;
#(
    parameter int               ADDR_W   = 32,
    parameter int               INSTR_W  = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ready,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               stall,
    input  logic               jump,
    input  logic               branch,
    input  logic               zero,
    input  logic [15:0]        branch_imm,
    output logic [INSTR_W-1:0] instr_out,
    output logic [5:0]         opcode_out,
    output logic               instr_valid,
    output logic [ADDR_W-1:0]  pc_out,
    output logic [ADDR_W-1:0]  pc_plus4,
    output logic [31:0]        issue_count
);

    // Low bits forced to zero so a misaligned RESET_PC cannot break alignment
    localparam logic [ADDR_W-1:0] RESET_PC_ALIGNED = {RESET_PC[ADDR_W-1:2], 2'b00};

    logic [1:0]        state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] next_pc;

    assign pc_plus4 = pc + ADDR_W'(4);

    next_pc_calc u_next_pc_calc (
        .pc_plus4    (pc_plus4),
        .instr_index (instr_out[25:0]),
        .jump        (jump),
        .branch      (branch),
        .zero        (zero),
        .branch_imm  (branch_imm),
        .next_pc     (next_pc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            pc          <= RESET_PC_ALIGNED;
            instr_out   <= NOP;
            issue_count <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state <= ST_REQ;
                end
                ST_REQ: begin
                    if (imem_ready) begin
                        instr_out <= imem_rdata;
                        state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // Redirect inputs only matter on the cycle we leave ISSUE
                    if (!stall) begin
                        pc          <= next_pc;
                        issue_count <= issue_count + 32'd1;
                        state       <= ST_REQ;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign imem_req    = (state == ST_REQ);
    assign imem_addr   = pc;
    assign instr_valid = (state == ST_ISSUE);
    assign pc_out      = pc;
    assign opcode_out  = instr_out[31:26];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: sequential fetch, jump, branch, priority,
// memory wait plus stall, and reset during an outstanding request.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        jump;
    logic        branch;
    logic        zero;
    logic [15:0] branch_imm;
    logic [31:0] instr_out;
    logic [5:0]  opcode_out;
    logic        instr_valid;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
    logic [31:0] issue_count;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_count = 32'd0;

    always #5 clk = ~clk;

    instr_fetch_unit #(
        .ADDR_W   (32),
        .INSTR_W  (32),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .stall       (stall),
        .jump        (jump),
        .branch      (branch),
        .zero        (zero),
        .branch_imm  (branch_imm),
        .instr_out   (instr_out),
        .opcode_out  (opcode_out),
        .instr_valid (instr_valid),
        .pc_out      (pc_out),
        .pc_plus4    (pc_plus4),
        .issue_count (issue_count)
    );

    // Presents one word with zero wait; called on a negedge while in REQ,
    // returns on the negedge where the DUT is in ISSUE.
    task automatic serve(input logic [31:0] word);
        imem_rdata = word;
        imem_ready = 1'b1;
        @(negedge clk);
        imem_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; imem_ready = 1'b0; imem_rdata = 32'h0; stall = 1'b0;
        jump = 1'b0; branch = 1'b0; zero = 1'b0; branch_imm = 16'h0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b expected 0", imem_req); end
        n_checks++;
        if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", instr_valid); end
        n_checks++;
        if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %h expected 00000000", imem_addr); end
        n_checks++;
        if (instr_out !== 32'h0) begin n_fail++; $display("FAIL reset_instr: got %h expected 00000000", instr_out); end
        n_checks++;
        if (issue_count !== 32'h0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", issue_count); end
    endtask

    task automatic test_sequential();
        imem_rdata = 32'h0000_0020;
        imem_ready = 1'b1;
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0 || instr_valid !== 1'b0) begin
            n_fail++; $display("FAIL first_req: req %b addr %h valid %b, expected 1 00000000 0", imem_req, imem_addr, instr_valid);
        end
        @(negedge clk);
        imem_ready = 1'b0;
        n_checks++;
        if (instr_valid !== 1'b1 || instr_out !== 32'h0000_0020 || opcode_out !== 6'd0) begin
            n_fail++; $display("FAIL first_issue: valid %b instr %h op %h, expected 1 00000020 00", instr_valid, instr_out, opcode_out);
        end
        n_checks++;
        if (pc_out !== 32'h0 || pc_plus4 !== 32'h4) begin
            n_fail++; $display("FAIL first_pc: pc %h pc4 %h, expected 00000000 00000004", pc_out, pc_plus4);
        end
        @(negedge clk);
        exp_count++;
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h4 || instr_valid !== 1'b0 || issue_count !== exp_count) begin
            n_fail++; $display("FAIL seq_next: req %b addr %h valid %b count %0d, expected 1 00000004 0 %0d", imem_req, imem_addr, instr_valid, issue_count, exp_count);
        end
        for (int i = 1; i < 4; i++) begin
            serve(32'h0000_0000);
            n_checks++;
            if (pc_out !== 32'(i * 4)) begin n_fail++; $display("FAIL seq_pc%0d: got %h expected %h", i, pc_out, 32'(i * 4)); end
            @(negedge clk);
            exp_count++;
            n_checks++;
            if (imem_addr !== 32'((i + 1) * 4) || issue_count !== exp_count) begin
                n_fail++; $display("FAIL seq_addr%0d: addr %h count %0d, expected %h %0d", i, imem_addr, issue_count, 32'((i + 1) * 4), exp_count);
            end
        end
    endtask

    task automatic test_jump();
        serve(32'h0800_0040);
        n_checks++;
        if (pc_out !== 32'h10 || opcode_out !== 6'b000010) begin
            n_fail++; $display("FAIL jump_issue: pc %h op %b, expected 00000010 000010", pc_out, opcode_out);
        end
        jump = 1'b1;
        @(negedge clk);
        jump = 1'b0;
        exp_count++;
        n_checks++;
        if (imem_addr !== 32'h0000_0100) begin n_fail++; $display("FAIL jump_target: got %h expected 00000100", imem_addr); end
        serve(32'h0800_0008);
        jump = 1'b1;
        @(negedge clk);
        jump = 1'b0;
        exp_count++;
        n_checks++;
        if (imem_addr !== 32'h0000_0020) begin n_fail++; $display("FAIL jump_back: got %h expected 00000020", imem_addr); end
    endtask

    task automatic test_branch();
        serve(32'h1000_FFFE);
        n_checks++;
        if (opcode_out !== 6'b000100) begin n_fail++; $display("FAIL beq_opcode: got %b expected 000100", opcode_out); end
        branch = 1'b1; zero = 1'b1; branch_imm = 16'hFFFE;
        @(negedge clk);
        branch = 1'b0; zero = 1'b0; branch_imm = 16'h0;
        exp_count++;
        n_checks++;
        if (imem_addr !== 32'h0000_001C) begin n_fail++; $display("FAIL branch_taken: got %h expected 0000001c", imem_addr); end
        serve(32'h0000_0000);
        @(negedge clk);
        exp_count++;
        n_checks++;
        if (imem_addr !== 32'h0000_0020) begin n_fail++; $display("FAIL branch_seq: got %h expected 00000020", imem_addr); end
        serve(32'h1000_FFFE);
        branch = 1'b1; zero = 1'b0; branch_imm = 16'hFFFE;
        @(negedge clk);
        branch = 1'b0; branch_imm = 16'h0;
        exp_count++;
        n_checks++;
        if (imem_addr !== 32'h0000_0024 || issue_count !== exp_count) begin
            n_fail++; $display("FAIL branch_not_taken: addr %h count %0d, expected 00000024 %0d", imem_addr, issue_count, exp_count);
        end
    endtask

    task automatic test_jump_priority();
        serve(32'h0800_0080);
        jump = 1'b1; branch = 1'b1; zero = 1'b1; branch_imm = 16'h0010;
        @(negedge clk);
        jump = 1'b0; branch = 1'b0; zero = 1'b0; branch_imm = 16'h0;
        exp_count++;
        n_checks++;
        if (imem_addr !== 32'h0000_0200) begin n_fail++; $display("FAIL jump_priority: got %h expected 00000200", imem_addr); end
    endtask

    task automatic test_wait_and_stall();
        imem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (imem_req !== 1'b1 || imem_addr !== 32'h0000_0200 || instr_valid !== 1'b0) begin
                n_fail++; $display("FAIL mem_wait%0d: req %b addr %h valid %b, expected 1 00000200 0", i, imem_req, imem_addr, instr_valid);
            end
        end
        serve(32'h2008_0005);
        // Stray ready and a jump request while stalled must both be ignored
        stall = 1'b1; jump = 1'b1; imem_ready = 1'b1; imem_rdata = 32'hFFFF_FFFF;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++;
            if (instr_valid !== 1'b1 || instr_out !== 32'h2008_0005 || pc_out !== 32'h0000_0200 || issue_count !== exp_count || imem_req !== 1'b0) begin
                n_fail++; $display("FAIL stall_hold%0d: valid %b instr %h pc %h count %0d req %b, expected 1 20080005 00000200 %0d 0", i, instr_valid, instr_out, pc_out, issue_count, exp_count, imem_req);
            end
        end
        stall = 1'b0; jump = 1'b0; imem_ready = 1'b0;
        @(negedge clk);
        exp_count++;
        n_checks++;
        if (imem_addr !== 32'h0000_0204 || instr_valid !== 1'b0 || issue_count !== exp_count) begin
            n_fail++; $display("FAIL stall_release: addr %h valid %b count %0d, expected 00000204 0 %0d", imem_addr, instr_valid, issue_count, exp_count);
        end
        @(negedge clk);
        n_checks++;
        if (issue_count !== exp_count) begin n_fail++; $display("FAIL stall_count_once: got %0d expected %0d", issue_count, exp_count); end
    endtask

    task automatic test_reset_during_req();
        reset = 1'b1;
        imem_ready = 1'b0;
        @(negedge clk);
        n_checks++;
        if (imem_req !== 1'b0 || instr_valid !== 1'b0 || imem_addr !== 32'h0 || issue_count !== 32'h0) begin
            n_fail++; $display("FAIL req_reset: req %b valid %b addr %h count %0d, expected 0 0 00000000 0", imem_req, instr_valid, imem_addr, issue_count);
        end
        reset = 1'b0;
        imem_ready = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        imem_ready = 1'b0;
        n_checks++;
        if (instr_valid !== 1'b0 || instr_out !== 32'h0 || imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            n_fail++; $display("FAIL stray_ready: valid %b instr %h req %b addr %h, expected 0 00000000 1 00000000", instr_valid, instr_out, imem_req, imem_addr);
        end
        serve(32'h0000_0020);
        n_checks++;
        if (instr_valid !== 1'b1 || instr_out !== 32'h0000_0020 || pc_out !== 32'h0) begin
            n_fail++; $display("FAIL restart_issue: valid %b instr %h pc %h, expected 1 00000020 00000000", instr_valid, instr_out, pc_out);
        end
        @(negedge clk);
        n_checks++;
        if (imem_addr !== 32'h4 || issue_count !== 32'd1) begin
            n_fail++; $display("FAIL restart_next: addr %h count %0d, expected 00000004 1", imem_addr, issue_count);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_jump();
        test_branch();
        test_jump_priority();
        test_wait_and_stall();
        test_reset_during_req();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
